// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the MIDI router SPI shift register.
// SPI_CPOL sets the idle level the edge detector assumes after reset.
package shift_reg_pkg;

    localparam logic SPI_CPOL = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'b00,
        ACT_LOAD  = 2'b01,
        ACT_SHIFT = 2'b10
    } sr_act_e;

endpackage

// File: rtl/shift_reg_if.sv
// Serial and parallel signal bundle between the SPI shift register and its users.
// The master side drives sck, MOSI and the parallel load; the slave side returns MISO and the register view.
interface shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             sck;
    logic             ser_i;
    logic             ser_o;
    logic             ld;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;

    modport master (
        output sck, ser_i, ld, data_i,
        input  ser_o, data_o
    );

    modport slave (
        input  sck, ser_i, ld, data_i,
        output ser_o, data_o
    );
endinterface

// File: rtl/shift_reg_sck_edge_det.sv
// Samples sck and MOSI on clk and flags a rising sck edge.
// ser_i_q holds the MOSI bit seen while sck was still low, aligned with the rise.
module sck_edge_det
    import shift_reg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic ser_i,
    output logic sck_rise,
    output logic ser_i_q
);

    logic sck_q;
    logic sck_d;
    logic ser_i_d;

    // Next-state values for the sampling flops.
    always_comb begin
        sck_d   = sck;
        ser_i_d = ser_i;
    end

    // Sampling flops; sck_q resets to the idle level so release never fakes a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q   <= SPI_CPOL;
            ser_i_q <= 1'b0;
        end else begin
            sck_q   <= sck_d;
            ser_i_q <= ser_i_d;
        end
    end

    assign sck_rise = sck & ~sck_q;

endmodule

// File: rtl/shift_reg.sv
// SPI-slave style shift register: parallel load, MSB-first serial out, serial in on sck rise.
// No framing here; the surrounding logic holds sck high between transfers.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_reg_if.slave  bus
);

    logic             sck_rise_s;
    logic             ser_i_q_s;
    sr_act_e          act_s;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    sck_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (bus.sck),
        .ser_i    (bus.ser_i),
        .sck_rise (sck_rise_s),
        .ser_i_q  (ser_i_q_s)
    );

    // Load beats shift: a rise coinciding with ld is dropped.
    always_comb begin
        act_s = ACT_HOLD;
        if (bus.ld) begin
            act_s = ACT_LOAD;
        end else if (sck_rise_s) begin
            act_s = ACT_SHIFT;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next register value for the selected action.
    always_comb begin
        sr_d = sr_q;
        case (act_s)
            ACT_LOAD:  sr_d = bus.data_i;
            ACT_SHIFT: sr_d = {sr_q[WIDTH-2:0], ser_i_q_s};
            ACT_HOLD:  sr_d = sr_q;
            default:   sr_d = sr_q;
        endcase
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {WIDTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bus.ser_o  = sr_q[WIDTH-1];
    assign bus.data_o = sr_q;

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: vector table, SPI exchange sequences and a random run
// against a history-based model of the sampled sck/MOSI streams.
module tb_shift_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_reg_if #(.WIDTH(8)) bus ();

    shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] data_i;
        logic       sck;
        logic       ser_i;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] val);
        bus.ld     = 1'b1;
        bus.data_i = val;
        bus.sck    = 1'b1;
        cyc();
        bus.ld     = 1'b0;
    endtask

    // Master clocks 8 bits: MISO sampled in the low phase, MOSI changed right after each rise.
    task automatic shift_byte(input logic [7:0] mosi, output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) begin
            bus.sck   = 1'b0;
            bus.ser_i = mosi[i];
            cyc();
            miso[i]   = bus.ser_o;
            bus.sck   = 1'b1;
            if (i > 0) bus.ser_i = mosi[i-1];
            else       bus.ser_i = 1'($urandom_range(1, 0));
            cyc();
        end
    endtask

    initial begin
        logic [7:0] miso;
        logic       sck_h[$];
        logic       ser_h[$];
        logic [7:0] model;
        int         k;

        checks = 0;
        errors = 0;

        tbl[0]  = '{1'b1, 8'hDE, 1'b1, 1'b0, 8'hDE};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hDE};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hDE};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hBD};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hBD};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h7A};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h7A};
        tbl[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C};
        tbl[8]  = '{1'b1, 8'h81, 1'b1, 1'b0, 8'h81};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h81};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03};
        tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h55};
        tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'hAA};
        tbl[13] = '{1'b1, 8'h0F, 1'b1, 1'b0, 8'h0F};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0F};

        // Reset with arbitrary inputs
        rst_n      = 1'b0;
        bus.sck    = 1'($urandom_range(1, 0));
        bus.ser_i  = 1'($urandom_range(1, 0));
        bus.ld     = 1'b1;
        bus.data_i = 8'($urandom);
        cyc();
        cyc();
        check("reset_data_o", bus.data_o, 8'h00);
        check("reset_ser_o", {7'b0, bus.ser_o}, 8'h00);
        bus.ld    = 1'b0;
        bus.sck   = 1'b1;
        bus.ser_i = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("release_idle_data_o", bus.data_o, 8'h00);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            bus.ld     = tbl[i].ld;
            bus.data_i = tbl[i].data_i;
            bus.sck    = tbl[i].sck;
            bus.ser_i  = tbl[i].ser_i;
            cyc();
            check($sformatf("tbl%0d_data_o", i), bus.data_o, tbl[i].exp);
            check($sformatf("tbl%0d_ser_o", i), {7'b0, bus.ser_o}, {7'b0, tbl[i].exp[7]});
        end
        bus.ld = 1'b0;
        bus.sck = 1'b1;
        cyc();

        // Load then exchange
        do_load(8'hDE);
        check("load_DE_data_o", bus.data_o, 8'hDE);
        check("load_DE_ser_o", {7'b0, bus.ser_o}, 8'h01);
        shift_byte(8'hDE, miso);
        check("xfer_DE_miso", miso, 8'hDE);
        check("xfer_DE_data_o", bus.data_o, 8'hDE);

        do_load(8'hA5);
        shift_byte(8'h3C, miso);
        check("xfer_A5_miso", miso, 8'hA5);
        check("xfer_3C_data_o", bus.data_o, 8'h3C);

        // Idle high for a while: hold
        repeat (5) cyc();
        check("idle_hold", bus.data_o, 8'h3C);

        // Bits beyond WIDTH: two bytes in a row, only the last survives
        do_load(8'h00);
        shift_byte(8'hC3, miso);
        shift_byte(8'h96, miso);
        check("overrun_miso", miso, 8'hC3);
        check("overrun_data_o", bus.data_o, 8'h96);

        // Reset mid-transfer
        do_load(8'hFF);
        for (int i = 0; i < 3; i++) begin
            bus.sck   = 1'b0;
            bus.ser_i = 1'b1;
            cyc();
            bus.sck   = 1'b1;
            cyc();
        end
        check("pre_reset_data_o", bus.data_o, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data_o", bus.data_o, 8'h00);
        check("async_reset_ser_o", {7'b0, bus.ser_o}, 8'h00);
        bus.sck = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        shift_byte(8'h55, miso);
        check("post_reset_miso", miso, 8'h00);
        check("post_reset_data_o", bus.data_o, 8'h55);

        // Random run against a model over the sampled input history
        bus.ld    = 1'b0;
        bus.sck   = 1'b1;
        bus.ser_i = 1'($urandom_range(1, 0));
        cyc();
        sck_h.push_back(bus.sck);
        ser_h.push_back(bus.ser_i);
        model = 8'h00;
        for (int n = 0; n < 400; n++) begin
            bus.ld     = (n == 0) || ($urandom_range(15, 0) == 0);
            bus.data_i = 8'($urandom);
            bus.sck    = 1'($urandom_range(1, 0));
            bus.ser_i  = 1'($urandom_range(1, 0));
            sck_h.push_back(bus.sck);
            ser_h.push_back(bus.ser_i);
            k = sck_h.size() - 1;
            if (bus.ld)
                model = bus.data_i;
            else if (sck_h[k] == 1'b1 && sck_h[k-1] == 1'b0)
                model = 8'((model * 2) + ser_h[k-1]);
            cyc();
            check($sformatf("rand%0d_data_o", n), bus.data_o, model);
            check($sformatf("rand%0d_ser_o", n), {7'b0, bus.ser_o}, {7'b0, model[7]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
